// File: rtl/spram_rr_arbiter.sv
// rtl/spram_rr_arbiter.sv - two-port round-robin arbiter/sequencer for the 8-bit single-port RAM
// Optional grant statistics counters enabled by defining SPRAM_ARB_STATS_EN.
module spram_rr_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_enable,
  output logic              ram_read_enable,
  input  logic [DATA_W-1:0] ram_data_out
`ifdef SPRAM_ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1
`endif
);

  localparam logic PRI0 = 1'b0;
  localparam logic PRI1 = 1'b1;

  logic              state_q, state_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_re_q, ram_re_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic [RD_LAT:0]   tag_vld_q, tag_vld_d;
  logic [RD_LAT:0]   tag_port_q, tag_port_d;

  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  // Readys are gated by reset so nothing is granted while the block is held in reset.
  always_comb begin
    grant0 = reset & req0_valid & (~req1_valid | (state_q == PRI0));
    grant1 = reset & req1_valid & (~req0_valid | (state_q == PRI1));
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;

  always_comb begin
    acc_we    = grant1 ? req1_we    : req0_we;
    acc_addr  = grant1 ? req1_addr  : req0_addr;
    acc_wdata = grant1 ? req1_wdata : req0_wdata;
  end

  always_comb begin
    state_d = state_q;
    if (grant0) begin
      state_d = PRI1;
    end else if (grant1) begin
      state_d = PRI0;
    end
  end

  always_comb begin
    ram_we_d   = accept & acc_we;
    ram_re_d   = accept & ~acc_we;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    if (accept) begin
      ram_addr_d = acc_addr;
      if (acc_we) begin
        ram_din_d = acc_wdata;
      end
    end
  end

  // Stage k of the tag pipe is visible k+1 cycles after accept; the last stage lines up with RAM data.
  always_comb begin
    tag_vld_d  = {tag_vld_q[RD_LAT-1:0], accept & ~acc_we};
    tag_port_d = {tag_port_q[RD_LAT-1:0], grant1};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= PRI0;
      ram_we_q   <= 1'b0;
      ram_re_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      tag_vld_q  <= '0;
      tag_port_q <= '0;
    end else begin
      state_q    <= state_d;
      ram_we_q   <= ram_we_d;
      ram_re_q   <= ram_re_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      tag_vld_q  <= tag_vld_d;
      tag_port_q <= tag_port_d;
    end
  end

  assign ram_address      = ram_addr_q;
  assign ram_data_in      = ram_din_q;
  assign ram_write_enable = ram_we_q;
  assign ram_read_enable  = ram_re_q;

  assign rsp0_valid = tag_vld_q[RD_LAT] & ~tag_port_q[RD_LAT];
  assign rsp1_valid = tag_vld_q[RD_LAT] &  tag_port_q[RD_LAT];
  assign rsp0_rdata = rsp0_valid ? ram_data_out : '0;
  assign rsp1_rdata = rsp1_valid ? ram_data_out : '0;

`ifdef SPRAM_ARB_STATS_EN
  logic [15:0] grant_cnt0_q, grant_cnt0_d;
  logic [15:0] grant_cnt1_q, grant_cnt1_d;

  // Clear takes priority over a same-cycle grant; counts stick at all-ones.
  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    if (stats_clr) begin
      grant_cnt0_d = 16'd0;
      grant_cnt1_d = 16'd0;
    end else begin
      if (grant0 && (grant_cnt0_q != 16'hFFFF)) begin
        grant_cnt0_d = grant_cnt0_q + 16'd1;
      end
      if (grant1 && (grant_cnt1_q != 16'hFFFF)) begin
        grant_cnt1_d = grant_cnt1_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant_cnt0_q <= 16'd0;
      grant_cnt1_q <= 16'd0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_spram_rr_arbiter.sv
// tb/tb_spram_rr_arbiter.sv - randomized and directed bench for spram_rr_arbiter with a behavioural model
module tb_spram_rr_arbiter;
  localparam int RD_LAT = 1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req0_valid, req0_ready, req0_we, rsp0_valid;
  logic [7:0] req0_addr, req0_wdata, rsp0_rdata;
  logic       req1_valid, req1_ready, req1_we, rsp1_valid;
  logic [7:0] req1_addr, req1_wdata, rsp1_rdata;
  logic [7:0] ram_address, ram_data_in, ram_data_out;
  logic       ram_write_enable, ram_read_enable;
`ifdef SPRAM_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  always #5 clock = ~clock;

  spram_rr_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_write_enable(ram_write_enable), .ram_read_enable(ram_read_enable),
    .ram_data_out(ram_data_out)
`ifdef SPRAM_ARB_STATS_EN
    , .stats_clr(stats_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // RAM: preloaded with addr^8'h5A, read data appears RD_LAT cycles after sampling read_enable.
  logic [7:0] mem [256];
  logic [7:0] rd_pipe [RD_LAT];
  logic       mem_ready = 1'b0;
  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
      for (int k = 0; k < RD_LAT; k++) rd_pipe[k] <= 8'h00;
      mem_ready <= 1'b1;
    end else begin
      if (ram_write_enable) mem[ram_address] <= ram_data_in;
      if (ram_read_enable) rd_pipe[0] <= mem[ram_address];
      for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
  end
  assign ram_data_out = rd_pipe[RD_LAT-1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: priority turn, shadow memory, queue of due responses.
  typedef struct {
    int         due;
    logic       port;
    logic [7:0] data;
  } rsp_t;
  rsp_t       rq[$];
  rsp_t       r;
  int         cyc = 0;
  logic       turn = 1'b0;
  logic       m_we = 1'b0, m_re = 1'b0;
  logic [7:0] m_addr = 8'h00, m_din = 8'h00;
  logic [7:0] shadow [256];
  logic       sh_init = 1'b0;
  logic       acc0_m = 1'b0, acc1_m = 1'b0;
  logic       g0, g1, e0, e1, a_we;
  logic [7:0] ed, a_addr, a_dat;
`ifdef SPRAM_ARB_STATS_EN
  logic [15:0] m_cnt0 = 16'd0, m_cnt1 = 16'd0;
`endif

  always @(negedge clock) begin
    cyc++;
    if (!sh_init) begin
      for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'h5A;
      sh_init = 1'b1;
    end
    if (!reset) begin
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_en", {ram_write_enable, ram_read_enable}, 0);
      chk("rst_pins", {ram_address, ram_data_in}, 0);
      chk("rst_rsp", {rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata}, 0);
      turn = 1'b0; m_we = 1'b0; m_re = 1'b0; m_addr = 8'h00; m_din = 8'h00;
      rq.delete();
      acc0_m = 1'b0; acc1_m = 1'b0;
`ifdef SPRAM_ARB_STATS_EN
      m_cnt0 = 16'd0; m_cnt1 = 16'd0;
      chk("rst_cnt", {grant_cnt0, grant_cnt1}, 0);
`endif
    end else begin
      if (m_we) shadow[m_addr] = m_din;
      g0 = req0_valid && (!req1_valid || turn == 1'b0);
      g1 = req1_valid && !g0;
      chk("ready0", req0_ready, g0);
      chk("ready1", req1_ready, g1);
      chk("ram_we", ram_write_enable, m_we);
      chk("ram_re", ram_read_enable, m_re);
      chk("ram_addr", ram_address, m_addr);
      chk("ram_din", ram_data_in, m_din);
      e0 = 1'b0; e1 = 1'b0; ed = 8'h00;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        if (r.port) e1 = 1'b1; else e0 = 1'b1;
        ed = r.data;
      end
      chk("rsp0_valid", rsp0_valid, e0);
      chk("rsp1_valid", rsp1_valid, e1);
      chk("rsp0_rdata", rsp0_rdata, e0 ? ed : 8'h00);
      chk("rsp1_rdata", rsp1_rdata, e1 ? ed : 8'h00);
`ifdef SPRAM_ARB_STATS_EN
      chk("cnt0", grant_cnt0, m_cnt0);
      chk("cnt1", grant_cnt1, m_cnt1);
      if (stats_clr) begin
        m_cnt0 = 16'd0; m_cnt1 = 16'd0;
      end else begin
        if (g0 && m_cnt0 != 16'hFFFF) m_cnt0 = m_cnt0 + 16'd1;
        if (g1 && m_cnt1 != 16'hFFFF) m_cnt1 = m_cnt1 + 16'd1;
      end
`endif
      acc0_m = g0; acc1_m = g1;
      if (g0 || g1) begin
        a_we   = g1 ? req1_we : req0_we;
        a_addr = g1 ? req1_addr : req0_addr;
        a_dat  = g1 ? req1_wdata : req0_wdata;
        m_we = a_we; m_re = !a_we; m_addr = a_addr;
        if (a_we) m_din = a_dat;
        else rq.push_back('{due: cyc + 1 + RD_LAT, port: g1, data: shadow[a_addr]});
        turn = g1 ? 1'b0 : 1'b1;
      end else begin
        m_we = 1'b0; m_re = 1'b0;
      end
    end
  end

  initial begin
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h20; req0_wdata = 8'h00;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h30; req1_wdata = 8'h00;
`ifdef SPRAM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) @(negedge clock);
    chk("lit_rst_readys", {req1_ready, req0_ready}, 2'b00);
    chk("lit_rst_en", {ram_write_enable, ram_read_enable}, 2'b00);
    @(posedge clock); #1;
    reset = 1'b1;

    // Contention: grants must alternate starting with port 0.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("lit_cont_grant", {req1_ready, req0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("lit_cont_en", {ram_write_enable, ram_read_enable}, (i > 0) ? 2'b01 : 2'b00);
      @(posedge clock); #1;
      if (i % 2 == 0) req0_addr = req0_addr + 8'd1;
      else req1_addr = req1_addr + 8'd1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Port 1 writes A5 @10, port 0 reads it back.
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 8'h10; req1_wdata = 8'hA5;
    @(negedge clock);
    chk("lit_wr_grant", req1_ready, 1);
    @(posedge clock); #1;
    req1_valid = 1'b0; req1_we = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h10;
    @(negedge clock);
    chk("lit_rd_grant", req0_ready, 1);
    @(posedge clock); #1;
    req0_valid = 1'b0;
    @(negedge clock);
    chk("lit_rd_early", rsp0_valid, 0);
    @(negedge clock);
    chk("lit_rd_valid", rsp0_valid, 1);
    chk("lit_rd_data", rsp0_rdata, 8'hA5);
    @(posedge clock); #1;

    // Streaming: 8 back-to-back reads of addresses 0..7.
    req0_valid = 1'b1; req0_addr = 8'h00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (i < 8) chk("lit_stream_ready", req0_ready, 1);
      if (i >= 2) begin
        chk("lit_stream_valid", rsp0_valid, 1);
        chk("lit_stream_data", rsp0_rdata, 8'(i - 2) ^ 8'h5A);
      end
      @(posedge clock); #1;
      req0_addr = 8'(i + 1);
      req0_valid = (i + 1 < 8);
    end

    // Mid-read reset: response dropped, priority back to port 0.
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h03;
    @(negedge clock);
    chk("lit_mr_accept", req0_ready, 1);
    @(posedge clock); #1;
    req0_valid = 1'b0; reset = 1'b0;
    @(negedge clock);
    chk("lit_mr_rsp_a", rsp0_valid, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("lit_mr_rsp_b", rsp0_valid, 0);
    @(posedge clock); #1;
    req0_valid = 1'b1; req1_valid = 1'b1; req0_addr = 8'h04; req1_addr = 8'h05;
    @(negedge clock);
    chk("lit_mr_pri", {req1_ready, req0_ready}, 2'b01);
    @(posedge clock); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;

`ifdef SPRAM_ARB_STATS_EN
    stats_clr = 1'b1;
    @(posedge clock); #1;
    stats_clr = 1'b0; req0_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    req1_valid = 1'b0;
    @(negedge clock);
    chk("lit_stats_cnt0", grant_cnt0, 16'd3);
    chk("lit_stats_cnt1", grant_cnt1, 16'd5);
    @(posedge clock); #1;
    stats_clr = 1'b1;
    @(posedge clock); #1;
    stats_clr = 1'b0;
    @(negedge clock);
    chk("lit_stats_clr", {grant_cnt0, grant_cnt1}, 32'd0);
`endif

    // Random traffic: commands held until the model says they were accepted.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock); #1;
      if (!req0_valid || acc0_m) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_we    = 1'($urandom_range(0, 1));
        req0_addr  = 8'($urandom_range(0, 15));
        req0_wdata = 8'($urandom);
      end
      if (!req1_valid || acc1_m) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_we    = 1'($urandom_range(0, 1));
        req1_addr  = 8'($urandom_range(0, 15));
        req1_wdata = 8'($urandom);
      end
`ifdef SPRAM_ARB_STATS_EN
      stats_clr = ($urandom_range(0, 63) == 0);
`endif
    end
    @(posedge clock); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
`ifdef SPRAM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (6) @(negedge clock);
    chk("drain_queue", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
